uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between NUM_REQ byte-stream requesters, such as the CPU console, a debug/trace unit, and a boot-status reporter. Arbitration is round-robin and packet-aware: a winner keeps the transmitter until it flags a last byte or reaches MAX_BURST bytes. The block sits between the requesters and the UART TX core, and drives that core's start/data strobe while waiting on its done pulse.

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-aware sharing of one UART transmitter between NUM_REQ byte streams.
// A winner holds the transmitter until its last byte or MAX_BURST bytes (0 = unlimited).
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 active
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d, last_grant_q, last_grant_d, pick, idx;
    logic [7:0]         burst_cnt_q, burst_cnt_d, tx_data_q, tx_data_d;
    logic               last_flag_q, last_flag_d, tx_start_q, tx_start_d, active_q, active_d;
    logic               found, release_now;

    // Scan from the requester after the last owner so the releaser ends up lowest priority.
    always_comb begin
        pick  = last_grant_q;
        idx   = last_grant_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
        tx_start_d   = 1'b0;
        release_now  = last_flag_q || (MAX_BURST != 0 && burst_cnt_q == 8'(MAX_BURST));
        case (state_q)
            IDLE: if (found) begin
                state_d     = ISSUE;
                gidx_d      = pick;
                grant_d     = NUM_REQ'(1) << pick;
                burst_cnt_d = '0;
            end
            ISSUE: if (req_valid[gidx_q]) begin
                state_d     = WAIT;
                tx_data_d   = req_data[{gidx_q, 3'b000} +: 8];
                last_flag_d = req_last[gidx_q];
                burst_cnt_d = burst_cnt_q + 8'd1;
                tx_start_d  = 1'b1;
            end else begin
                state_d      = IDLE;
                grant_d      = '0;
                last_grant_d = gidx_q;
            end
            WAIT: if (tx_done) begin
                state_d      = release_now ? IDLE : ISSUE;
                grant_d      = release_now ? '0 : grant_q;
                last_grant_d = release_now ? gidx_q : last_grant_q;
            end
            default: state_d = IDLE;
        endcase
        active_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            tx_data_q    <= '0;
            last_flag_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_data_q    <= tx_data_d;
            last_flag_q  <= last_flag_d;
            tx_start_q   <= tx_start_d;
            active_q     <= active_d;
        end
    end

    assign req_ready = (state_q == ISSUE) ? (grant_q & req_valid) : '0;
    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign active    = active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: arbitration vector table plus scoreboarded byte streams against a simple UART model.
module tb_uart_tx_arbiter;
    logic        clk, reset;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        tx_start, tx_done, active;
    logic [7:0]  tx_data;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .active(active)
    );

    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
    typedef struct packed {logic [3:0] mask; logic [3:0] exp_grant;} vec_t;

    int         checks = 0, errors = 0;
    exp_t       sb[$];
    logic [8:0] mem [4][32];
    int         head[4], tail[4];
    int         ucnt = 0, uart_lat = 0;
    bit         busy = 0, auto_drive = 0;
    vec_t       vecs[12];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_tx(input int id, input logic [7:0] d);
        sb.push_back({2'(id), d});
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic l);
        mem[id][tail[id]] = {l, d};
        tail[id]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (head[i] != tail[i]) return 0;
        return sb.size() == 0 && !busy;
    endfunction

    // One clock: score tx_start, run the UART model, drive requesters, then record handshakes.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (tx_start) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_start: got data %0h, required no start", tx_data);
            end else begin
                e = sb.pop_front();
                chk("tx_grant", 32'(grant), 32'(1) << e.id);
                chk("tx_data", 32'(tx_data), 32'(e.data));
            end
            busy = 1;
            ucnt = uart_lat;
        end
        tx_done = 0;
        if (busy) begin
            if (ucnt == 0) begin
                tx_done = 1;
                busy    = 0;
            end else ucnt--;
        end
        if (auto_drive)
            for (int i = 0; i < 4; i++) begin
                req_valid[i]       = head[i] != tail[i];
                req_data[i*8 +: 8] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end
        #1;
        chk("ready_within_grant", 32'(req_ready & ~grant), 0);
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i] && head[i] != tail[i]) head[i]++;
    endtask

    task automatic do_reset();
        reset     = 1;
        req_valid = 0;
        req_data  = 0;
        req_last  = 0;
        tx_done   = 0;
        busy      = 0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        tick();
        while (!(all_empty() && !active)) begin
            if (n >= max) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got %0d queued, required 0", name, sb.size());
                return;
            end
            tick();
            n++;
        end
        chk({name, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    task automatic wait_grant(input string name, input logic [3:0] g);
        int n = 0;
        while (grant !== g && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(grant), 32'(g));
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 4'b0001};
        vecs[1]  = '{4'b0101, 4'b0100};
        vecs[2]  = '{4'b0101, 4'b0001};
        vecs[3]  = '{4'b1010, 4'b0010};
        vecs[4]  = '{4'b1010, 4'b1000};
        vecs[5]  = '{4'b0010, 4'b0010};
        vecs[6]  = '{4'b0010, 4'b0010};
        vecs[7]  = '{4'b1111, 4'b0100};
        vecs[8]  = '{4'b1011, 4'b1000};
        vecs[9]  = '{4'b1000, 4'b1000};
        vecs[10] = '{4'b0000, 4'b0000};
        vecs[11] = '{4'b0110, 4'b0010};

        do_reset();
        chk("reset_grant", 32'(grant), 0);
        chk("reset_tx_start", 32'(tx_start), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_active", 32'(active), 0);
        chk("reset_ready", 32'(req_ready), 0);

        // Each row arbitrates, then the winner abandons so it becomes last_grant for the next row.
        for (int r = 0; r < 12; r++) begin
            req_valid = vecs[r].mask;
            tick();
            chk($sformatf("vec%0d_grant", r), 32'(grant), 32'(vecs[r].exp_grant));
            chk($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(vecs[r].exp_grant));
            chk($sformatf("vec%0d_active", r), 32'(active), 32'(vecs[r].exp_grant != 0));
            req_valid = 0;
            #1;
            chk($sformatf("vec%0d_drop_ready", r), 32'(req_ready), 0);
            tick();
            chk($sformatf("vec%0d_release", r), 32'(grant), 0);
            chk($sformatf("vec%0d_idle", r), 32'(active), 0);
        end

        // Single byte with exact latency.
        do_reset();
        auto_drive = 1;
        uart_lat   = 2;
        expect_tx(0, 8'h41);
        load(0, 8'h41, 1);
        tick();
        chk("single_pre_grant", 32'(grant), 0);
        tick();
        chk("single_grant", 32'(grant), 32'b0001);
        chk("single_ready", 32'(req_ready), 32'b0001);
        chk("single_no_start", 32'(tx_start), 0);
        tick();
        chk("single_start", 32'(tx_start), 1);
        chk("single_data", 32'(tx_data), 32'h41);
        begin
            int n = 0;
            while (!tx_done && n < 10) begin
                tick();
                n++;
            end
            chk("single_done_seen", 32'(tx_done), 1);
        end
        tick();
        chk("single_end_grant", 32'(grant), 0);
        chk("single_end_active", 32'(active), 0);
        chk("single_data_hold", 32'(tx_data), 32'h41);

        // Round robin, with tx_done in the first WAIT cycle.
        do_reset();
        uart_lat = 0;
        expect_tx(0, 8'hA0);
        expect_tx(2, 8'hA2);
        expect_tx(0, 8'hB0);
        load(0, 8'hA0, 1);
        load(0, 8'hB0, 1);
        load(2, 8'hA2, 1);
        drain("rr1", 100);
        expect_tx(2, 8'hC2);
        load(2, 8'hC2, 1);
        drain("rr2", 50);
        expect_tx(3, 8'hD3);
        expect_tx(1, 8'hD1);
        load(3, 8'hD3, 1);
        load(1, 8'hD1, 1);
        drain("rr3", 100);

        // Burst lock: req1 keeps the transmitter through its packet despite req3.
        do_reset();
        uart_lat = 1;
        expect_tx(1, 8'h10);
        expect_tx(1, 8'h11);
        expect_tx(1, 8'h12);
        expect_tx(3, 8'h30);
        load(1, 8'h10, 0);
        load(1, 8'h11, 0);
        load(1, 8'h12, 1);
        wait_grant("burst_first_grant", 4'b0010);
        load(3, 8'h30, 1);
        drain("burst", 200);

        // MAX_BURST=4 forced release, then re-grant for the remainder.
        do_reset();
        for (int b = 0; b < 4; b++) expect_tx(2, 8'(8'h20 + b));
        expect_tx(0, 8'h05);
        expect_tx(2, 8'h24);
        expect_tx(2, 8'h25);
        for (int b = 0; b < 6; b++) load(2, 8'(8'h20 + b), 0);
        wait_grant("maxb_first_grant", 4'b0100);
        load(0, 8'h05, 1);
        drain("maxb", 300);

        // Abandon before ISSUE, next arbitration starts after the abandoner.
        do_reset();
        auto_drive = 0;
        req_valid  = 4'b0010;
        tick();
        chk("abandon_grant", 32'(grant), 32'b0010);
        req_valid = 0;
        #1;
        chk("abandon_no_ready", 32'(req_ready), 0);
        tick();
        chk("abandon_release", 32'(grant), 0);
        chk("abandon_no_start", 32'(tx_start), 0);
        req_valid = 4'b1111;
        tick();
        chk("abandon_next", 32'(grant), 32'b0100);
        req_valid = 0;
        tick();
        chk("abandon_idle", 32'(active), 0);

        // Asynchronous reset mid-byte.
        do_reset();
        auto_drive = 1;
        uart_lat   = 5;
        expect_tx(1, 8'h77);
        load(1, 8'h77, 1);
        begin
            int n = 0;
            while (!tx_start && n < 10) begin
                tick();
                n++;
            end
            chk("areset_started", 32'(tx_start), 1);
        end
        reset = 1;
        #1;
        chk("areset_grant", 32'(grant), 0);
        chk("areset_tx_start", 32'(tx_start), 0);
        chk("areset_tx_data", 32'(tx_data), 0);
        chk("areset_active", 32'(active), 0);
        do_reset();
        uart_lat = 1;
        expect_tx(0, 8'h0A);
        expect_tx(3, 8'h3A);
        load(3, 8'h3A, 1);
        load(0, 8'h0A, 1);
        drain("areset_after", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
